// File: rtl/sortmax_pkg.sv
// Shared types for the sort/extreme engine: FSM state encoding and the
// frame-mode encodings latched with each frame's first beat.
package sortmax_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SORT = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ASC  = 2'b00;
    localparam logic [1:0] MODE_DESC = 2'b01;
    localparam logic [1:0] MODE_MAX  = 2'b10;
    localparam logic [1:0] MODE_MIN  = 2'b11;

    function automatic logic is_sort(input logic [1:0] m);
        return !m[1];
    endfunction

endpackage

// File: rtl/sortmax_if.sv
// Stream handshake bundle for sortmax_engine: input words, result words
// and the busy flag. The engine side uses the slave modport.
interface sortmax_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             busy;

    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy
    );

endinterface

// File: rtl/sortmax_cas.sv
// Compare-and-swap cell: a sits at the lower index, b at the higher one.
// Swaps only on strict inequality so equal words keep their order.
module sortmax_cas #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             descending,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);
    logic swap;

    assign swap = descending ? (a < b) : (a > b);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/sortmax_engine.sv
// Frame engine: loads DEPTH words, then either sorts them with odd-even
// transposition or reports the running max/min tracked during the load.
module sortmax_engine
    import sortmax_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    sortmax_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] mem       [DEPTH];
    logic [WIDTH-1:0] even_next [DEPTH];
    logic [WIDTH-1:0] odd_next  [DEPTH];
    logic [IDX_W-1:0] cnt;
    logic [1:0]       frame_mode;
    logic [WIDTH-1:0] ext;
    logic [IDX_W-1:0] ext_idx;
    logic             rdy_en;
    logic             in_fire;
    logic             out_fire;
    logic             descending;
    logic             better;

    assign in_fire    = bus.in_valid && bus.in_ready;
    assign out_fire   = bus.out_valid && bus.out_ready;
    assign descending = (frame_mode == MODE_DESC);
    assign better     = ((frame_mode == MODE_MAX) && (bus.in_data > ext)) ||
                        ((frame_mode == MODE_MIN) && (bus.in_data < ext));

    // Even phase pairs (0,1),(2,3)...; odd phase pairs (1,2),(3,4)...
    for (genvar i = 0; i < DEPTH / 2; i++) begin : g_even
        sortmax_cas #(.WIDTH(WIDTH)) u_cas (
            .a(mem[2*i]), .b(mem[2*i+1]), .descending(descending),
            .lo(even_next[2*i]), .hi(even_next[2*i+1])
        );
    end
    if (DEPTH % 2 == 1) begin : g_even_tail
        assign even_next[DEPTH-1] = mem[DEPTH-1];
    end

    assign odd_next[0] = mem[0];
    for (genvar i = 0; i < (DEPTH - 1) / 2; i++) begin : g_odd
        sortmax_cas #(.WIDTH(WIDTH)) u_cas (
            .a(mem[2*i+1]), .b(mem[2*i+2]), .descending(descending),
            .lo(odd_next[2*i+1]), .hi(odd_next[2*i+2])
        );
    end
    if (DEPTH % 2 == 0) begin : g_odd_tail
        assign odd_next[DEPTH-1] = mem[DEPTH-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_fire) next_state = LOAD;
            LOAD: if (in_fire && cnt == LAST)
                      next_state = is_sort(frame_mode) ? SORT : OUT;
            SORT: if (cnt == LAST) next_state = OUT;
            OUT:  if (out_fire && bus.out_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // rdy_en keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            cnt        <= '0;
            frame_mode <= MODE_ASC;
            ext        <= '0;
            ext_idx    <= '0;
            rdy_en     <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                IDLE: if (in_fire) begin
                    mem[0]     <= bus.in_data;
                    frame_mode <= bus.mode;
                    ext        <= bus.in_data;
                    ext_idx    <= '0;
                    cnt        <= IDX_W'(1);
                end
                LOAD: if (in_fire) begin
                    mem[cnt] <= bus.in_data;
                    if (better) begin
                        ext     <= bus.in_data;
                        ext_idx <= cnt;
                    end
                    cnt <= (cnt == LAST) ? '0 : cnt + IDX_W'(1);
                end
                SORT: begin
                    for (int i = 0; i < DEPTH; i++)
                        mem[i] <= cnt[0] ? odd_next[i] : even_next[i];
                    cnt <= (cnt == LAST) ? '0 : cnt + IDX_W'(1);
                end
                OUT: if (out_fire && is_sort(frame_mode))
                    cnt <= (cnt == LAST) ? '0 : cnt + IDX_W'(1);
                default: cnt <= '0;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = rdy_en && ((state == IDLE) || (state == LOAD));
        bus.out_valid = (state == OUT);
        bus.busy      = (state != IDLE);
        bus.out_data  = '0;
        bus.out_idx   = '0;
        bus.out_last  = 1'b0;
        if (state == OUT) begin
            if (is_sort(frame_mode)) begin
                bus.out_data = mem[cnt];
                bus.out_idx  = cnt;
                bus.out_last = (cnt == LAST);
            end else begin
                bus.out_data = ext;
                bus.out_idx  = ext_idx;
                bus.out_last = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sortmax_engine.sv
// Scoreboard bench for sortmax_engine: a reference model queues expected
// result words and a negedge monitor checks every presented output word.
module tb_sortmax_engine;
    import sortmax_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int IDX_W = $clog2(DEPTH);

    typedef logic [WIDTH-1:0] frame_t [DEPTH];
    typedef struct {
        logic [WIDTH-1:0] data;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;

    sortmax_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sortmax_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s", name);
    endtask

    // Reference model: sorted order by repeated extraction, or first extreme.
    task automatic pushExpect(input logic [1:0] m, input frame_t v);
        exp_t e;
        logic [WIDTH-1:0] rem[$];
        if (is_sort(m)) begin
            for (int i = 0; i < DEPTH; i++) rem.push_back(v[i]);
            for (int p = 0; p < DEPTH; p++) begin
                int k = 0;
                for (int j = 1; j < rem.size(); j++)
                    if ((m == MODE_ASC) ? (rem[j] < rem[k]) : (rem[j] > rem[k])) k = j;
                e.data = rem[k];
                e.idx  = IDX_W'(p);
                e.last = (p == DEPTH - 1);
                sb.push_back(e);
                rem.delete(k);
            end
        end else begin
            e.data = v[0];
            e.idx  = '0;
            e.last = 1'b1;
            for (int i = 1; i < DEPTH; i++)
                if ((m == MODE_MAX) ? (v[i] > e.data) : (v[i] < e.data)) begin
                    e.data = v[i];
                    e.idx  = IDX_W'(i);
                end
            sb.push_back(e);
        end
    endtask

    task automatic sendBeat(input logic [WIDTH-1:0] d, input logic [1:0] m);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.mode     = m;
        while (!bus.in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) failNow("in_ready_timeout");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] mode0, input logic [1:0] mode_rest,
                                 input frame_t v, input bit expect_out, input int exp_lat);
        int lat = 1;
        if (expect_out) pushExpect(mode0, v);
        for (int i = 0; i < DEPTH; i++) sendBeat(v[i], (i == 0) ? mode0 : mode_rest);
        if (exp_lat > 0) begin
            while (!bus.out_valid && lat < 100) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checkOutput("latency", lat, exp_lat);
        end
    endtask

    task automatic waitIdle();
        int guard = 0;
        while ((sb.size() != 0 || bus.busy) && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 3000) failNow("drain_timeout");
        checkOutput("ready_after_frame", bus.in_ready, 1);
    endtask

    // Every presented word must match the queue head, stalled or not.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.out_valid) begin
                if (sb.size() == 0) begin
                    failNow("unexpected_beat");
                end else begin
                    e = sb[0];
                    checkOutput("out_data", bus.out_data, e.data);
                    checkOutput("out_idx", bus.out_idx, e.idx);
                    checkOutput("out_last", bus.out_last, e.last);
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        frame_t spec, v;
        logic [1:0] m;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.mode     = MODE_ASC;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_data", bus.out_data, 0);
        checkOutput("rst_out_idx", bus.out_idx, 0);
        checkOutput("rst_out_last", bus.out_last, 0);
        checkOutput("rst_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("ready_before_edge", bus.in_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("ready_after_edge", bus.in_ready, 1);

        spec = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2, 8'd8, 8'd4};
        $display("[TB] directed frames");
        applyStimulus(MODE_ASC, MODE_ASC, spec, 1'b1, DEPTH + 1);
        waitIdle();
        applyStimulus(MODE_DESC, MODE_DESC, spec, 1'b1, DEPTH + 1);
        waitIdle();
        applyStimulus(MODE_MAX, MODE_MAX, spec, 1'b1, 1);
        waitIdle();
        applyStimulus(MODE_MIN, MODE_MIN, spec, 1'b1, 1);
        waitIdle();

        v = '{8'd6, 8'd200, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        applyStimulus(MODE_MAX, MODE_MAX, v, 1'b1, 0);
        waitIdle();
        v = '{default: 8'd0};
        applyStimulus(MODE_MIN, MODE_MIN, v, 1'b1, 0);
        waitIdle();

        $display("[TB] mode change mid-frame");
        applyStimulus(MODE_ASC, MODE_DESC, spec, 1'b1, 0);
        waitIdle();

        $display("[TB] reset during sort");
        applyStimulus(MODE_ASC, MODE_ASC, spec, 1'b0, 0);
        @(posedge clk);
        #1;
        checkOutput("busy_in_sort", bus.busy, 1);
        rst = 1'b0;
        #1;
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_in_ready", bus.in_ready, 0);
        checkOutput("midrst_out_valid", bus.out_valid, 0);
        checkOutput("midrst_out_data", bus.out_data, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("idle_after_reset", bus.busy, 0);
        v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        applyStimulus(MODE_ASC, MODE_ASC, v, 1'b1, DEPTH + 1);
        waitIdle();

        $display("[TB] random backpressure");
        rand_ready = 1'b1;
        applyStimulus(MODE_ASC, MODE_ASC, spec, 1'b1, 0);
        waitIdle();
        for (int f = 0; f < 12; f++) begin
            m = 2'($urandom_range(0, 3));
            for (int i = 0; i < DEPTH; i++)
                v[i] = (f % 2 == 0) ? WIDTH'($urandom_range(0, 255)) : WIDTH'($urandom_range(0, 3));
            applyStimulus(m, 2'($urandom_range(0, 3)), v, 1'b1, 0);
            waitIdle();
        end
        rand_ready = 1'b0;

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
